// File: rtl/dense_pkg.sv
// ============================================================================
// dense_pkg : shared types and helpers for the dense-layer MAC sequencer
// Revision  : 1.0
// ============================================================================
`default_nettype none

package dense_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2,
    S_EMIT  = 2'd3
  } state_e;

  localparam int ACC_W_DEF = 32;

  // Address width for a memory of n words; never narrower than one bit.
  function automatic int addr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/dense_align.sv
// ============================================================================
// dense_align : RD_LAT-deep delay line turning fetch flags into MAC strobes
// Revision    : 1.0
// ============================================================================
`default_nettype none

module dense_align #(
  parameter int RD_LAT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic fetch_i,
  input  logic first_i,
  output logic mac_en_o,
  output logic mac_clr_o
);

  logic [RD_LAT-1:0] en_q;
  logic [RD_LAT-1:0] first_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      en_q    <= '0;
      first_q <= '0;
    end else begin
      en_q[0]    <= fetch_i;
      first_q[0] <= fetch_i & first_i;
      for (int i = 1; i < RD_LAT; i++) begin
        en_q[i]    <= en_q[i-1];
        first_q[i] <= first_q[i-1];
      end
    end
  end

  assign mac_en_o  = en_q[RD_LAT-1];
  assign mac_clr_o = en_q[RD_LAT-1] & first_q[RD_LAT-1];

endmodule

`default_nettype wire

// File: rtl/dense_seq.sv
// ============================================================================
// dense_seq : walks every neuron of a dense layer, drives reads and MAC
//             strobes, and hands each 32-bit result out on valid/ready
// Revision  : 1.0
// ============================================================================
`default_nettype none

module dense_seq
  import dense_pkg::*;
#(
  parameter int N_IN    = 16,
  parameter int N_OUT   = 4,
  parameter int ACC_W   = ACC_W_DEF,
  parameter int RD_LAT  = 1,
  parameter int MAC_LAT = 1,
  localparam int DAW    = addr_w(N_IN),
  localparam int WAW    = addr_w(N_IN * N_OUT),
  localparam int NW     = addr_w(N_OUT)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [DAW-1:0]   data_addr_o,
  output logic [WAW-1:0]   weight_addr_o,
  output logic             mac_en_o,
  output logic             mac_clr_o,
  input  logic [ACC_W-1:0] acc_in_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [ACC_W-1:0] out_data_o,
  output logic [NW-1:0]    out_idx_o
);

  localparam int D_LAT = RD_LAT + MAC_LAT;
  localparam int DW    = addr_w(D_LAT);

  localparam logic [DAW-1:0] K_LAST = DAW'(N_IN - 1);
  localparam logic [NW-1:0]  N_LAST = NW'(N_OUT - 1);
  localparam logic [DW-1:0]  D_LAST = DW'(D_LAT - 1);

  state_e             state_q, state_d;
  logic [DAW-1:0]     k_q, k_d;
  logic [NW-1:0]      n_q, n_d;
  logic [WAW-1:0]     wa_q, wa_d;
  logic [DW-1:0]      dcnt_q, dcnt_d;
  logic [ACC_W-1:0]   odata_q, odata_d;
  logic [NW-1:0]      oidx_q, oidx_d;
  logic               done_q, done_d;
  logic               fetch_w;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      n_q     <= '0;
      wa_q    <= '0;
      dcnt_q  <= '0;
      odata_q <= '0;
      oidx_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      n_q     <= n_d;
      wa_q    <= wa_d;
      dcnt_q  <= dcnt_d;
      odata_q <= odata_d;
      oidx_q  <= oidx_d;
      done_q  <= done_d;
    end
  end

  // The weight address advances by one per term and carries straight across
  // neurons, so n*N_IN+k is tracked without a multiplier.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    n_d     = n_q;
    wa_d    = wa_q;
    dcnt_d  = dcnt_q;
    odata_d = odata_q;
    oidx_d  = oidx_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_FETCH;
          k_d     = '0;
          n_d     = '0;
          wa_d    = '0;
        end
      end
      S_FETCH: begin
        if (k_q == K_LAST) begin
          state_d = S_DRAIN;
          dcnt_d  = '0;
        end else begin
          k_d  = k_q + 1'b1;
          wa_d = wa_q + 1'b1;
        end
      end
      S_DRAIN: begin
        if (dcnt_q == D_LAST) begin
          state_d = S_EMIT;
          odata_d = acc_in_i;
          oidx_d  = n_q;
        end else begin
          dcnt_d = dcnt_q + 1'b1;
        end
      end
      S_EMIT: begin
        if (out_ready_i) begin
          if (n_q == N_LAST) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = S_FETCH;
            n_d     = n_q + 1'b1;
            k_d     = '0;
            wa_d    = wa_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign fetch_w = (state_q == S_FETCH);

  dense_align #(
    .RD_LAT (RD_LAT)
  ) u_align (
    .clk       (clk),
    .rst       (rst),
    .fetch_i   (fetch_w),
    .first_i   (k_q == '0),
    .mac_en_o  (mac_en_o),
    .mac_clr_o (mac_clr_o)
  );

  assign busy_o        = (state_q != S_IDLE);
  assign done_o        = done_q;
  assign out_valid_o   = (state_q == S_EMIT);
  assign out_data_o    = odata_q;
  assign out_idx_o     = oidx_q;
  assign data_addr_o   = k_q;
  assign weight_addr_o = wa_q;

endmodule

`default_nettype wire

// File: tb/tb_dense_seq.sv
// ============================================================================
// tb_dense_seq : self-checking bench for dense_seq with memory and MAC models
// Revision     : 1.0
// ============================================================================
`default_nettype none

module tb_dense_seq;

  localparam int N_IN    = 4;
  localparam int N_OUT   = 2;
  localparam int ACC_W   = 32;
  localparam int RD_LAT  = 1;
  localparam int MAC_LAT = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        busy;
  logic        done;
  logic [1:0]  data_addr;
  logic [2:0]  weight_addr;
  logic        mac_en;
  logic        mac_clr;
  logic [31:0] acc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [0:0]  out_idx;

  always #5 clk = ~clk;

  dense_seq #(
    .N_IN    (N_IN),
    .N_OUT   (N_OUT),
    .ACC_W   (ACC_W),
    .RD_LAT  (RD_LAT),
    .MAC_LAT (MAC_LAT)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start_i       (start),
    .busy_o        (busy),
    .done_o        (done),
    .data_addr_o   (data_addr),
    .weight_addr_o (weight_addr),
    .mac_en_o      (mac_en),
    .mac_clr_o     (mac_clr),
    .acc_in_i      (acc),
    .out_valid_o   (out_valid),
    .out_ready_i   (out_ready),
    .out_data_o    (out_data),
    .out_idx_o     (out_idx)
  );

  typedef struct packed {
    logic [3:0][7:0]  d;
    logic [7:0][7:0]  w;
    logic [1:0][31:0] e;
  } vec_t;

  logic [7:0]  dmem [4];
  logic [7:0]  wmem [8];
  logic [7:0]  rd_d, rd_w;
  logic [31:0] prod;

  // One-cycle read memories and a load/accumulate MAC with one-cycle latency.
  always @(posedge clk) begin
    rd_d <= dmem[data_addr];
    rd_w <= wmem[weight_addr];
  end

  assign prod = {{24{rd_d[7]}}, rd_d} * {{24{rd_w[7]}}, rd_w};

  always @(posedge clk) begin
    if (rst)         acc <= '0;
    else if (mac_en) acc <= mac_clr ? prod : acc + prod;
  end

  int checks = 0;
  int fails  = 0;
  int done_cnt = 0;
  int n_results = 0;
  logic [32:0] sb [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (done) done_cnt++;
      if (out_valid) begin
        chk("emit_no_mac_en", {63'd0, mac_en}, 64'd0);
        if (sb.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_result: got data=0x%0h idx=%0d want none", out_data, out_idx);
        end else begin
          chk("result_data", {32'd0, out_data}, {32'd0, sb[0][31:0]});
          chk("result_idx", {63'd0, out_idx}, {63'd0, sb[0][32]});
          if (out_ready) begin
            void'(sb.pop_front());
            n_results++;
          end
        end
      end
    end
  end

  task automatic load_push(input vec_t v);
    for (int i = 0; i < 4; i++) dmem[i] = v.d[i];
    for (int i = 0; i < 8; i++) wmem[i] = v.w[i];
    for (int n = 0; n < N_OUT; n++) sb.push_back({1'(n), v.e[n]});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (out_valid) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic run_layer(input vec_t v, input string tag);
    bit ok;
    load_push(v);
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(ok);
    chk({tag, "_done_timeout"}, {63'd0, ok}, 64'd1);
    tick();
    chk({tag, "_sb_empty"}, 64'(sb.size()), 64'd0);
  endtask

  vec_t tbl [4];

  initial begin
    bit   ok;
    int   d0, r0;
    logic [4:0] ectl;

    // data d[0..3], weights w[0..3]=neuron0, w[4..7]=neuron1, expected results
    tbl[0] = '{d: {8'd1, 8'd1, 8'd1, 8'd1},
               w: {8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1},
               e: {32'd4, 32'd4}};
    tbl[1] = '{d: {8'd4, 8'd3, 8'd2, 8'd1},
               w: {8'd3, 8'hFF, 8'd0, 8'd2, 8'd1, 8'd1, 8'd1, 8'd1},
               e: {32'd11, 32'd10}};
    tbl[2] = '{d: {8'h80, 8'h80, 8'h80, 8'h80},
               w: {8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'h80, 8'h80, 8'h80, 8'h80},
               e: {32'hFFFF0200, 32'd65536}};
    tbl[3] = '{d: {8'd0, 8'd7, 8'hFD, 8'd5},
               w: {8'd3, 8'd3, 8'd3, 8'd3, 8'd9, 8'd0, 8'd2, 8'hFF},
               e: {32'd27, 32'hFFFFFFF5}};

    rst = 1'b1;
    start = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) dmem[i] = tbl[0].d[i];
    for (int i = 0; i < 8; i++) wmem[i] = tbl[0].w[i];
    repeat (3) tick();
    @(negedge clk);
    chk("reset_state",
        {22'd0, busy, done, mac_en, mac_clr, out_valid, data_addr, weight_addr, out_idx, out_data},
        64'd0);
    tick();
    rst = 1'b0;

    // Cycle-exact timing: start in cycle 0
    tick();
    load_push(tbl[0]);
    start = 1'b1;
    for (int c = 0; c <= 16; c++) begin
      @(negedge clk);
      ectl = {(c >= 1 && c <= 14),
              ((c >= 2 && c <= 5) || (c >= 9 && c <= 12)),
              (c == 2 || c == 9),
              (c == 7 || c == 14),
              (c == 15)};
      chk($sformatf("ctl_cyc%0d", c), {59'd0, busy, mac_en, mac_clr, out_valid, done}, {59'd0, ectl});
      if (c >= 1 && c <= 4)
        chk($sformatf("addr_cyc%0d", c), {59'd0, data_addr, weight_addr}, {59'd0, 2'(c - 1), 3'(c - 1)});
      if (c >= 8 && c <= 11)
        chk($sformatf("addr_cyc%0d", c), {59'd0, data_addr, weight_addr}, {59'd0, 2'(c - 8), 3'(c - 4)});
      tick();
      start = 1'b0;
    end
    chk("timing_sb_empty", 64'(sb.size()), 64'd0);

    // Table of value patterns
    for (int t = 0; t < 4; t++) run_layer(tbl[t], $sformatf("vec%0d", t));

    // Backpressure on the first result
    out_ready = 1'b0;
    load_push(tbl[1]);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_valid(ok);
    chk("bp_valid_timeout", {63'd0, ok}, 64'd1);
    repeat (4) tick();
    tick();
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_held_valid", {63'd0, out_valid}, 64'd1);
    tick();
    @(negedge clk);
    chk("bp_refetch0", {57'd0, out_valid, weight_addr, data_addr, mac_en}, {57'd0, 1'b0, 3'd4, 2'd0, 1'b0});
    tick();
    @(negedge clk);
    chk("bp_refetch1", {59'd0, weight_addr, mac_en, mac_clr}, {59'd0, 3'd5, 1'b1, 1'b1});
    wait_done(ok);
    chk("bp_done_timeout", {63'd0, ok}, 64'd1);
    tick();
    chk("bp_sb_empty", 64'(sb.size()), 64'd0);

    // start re-pulsed during FETCH and EMIT
    d0 = done_cnt;
    r0 = n_results;
    load_push(tbl[3]);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_valid(ok);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(ok);
    repeat (20) tick();
    chk("restart_done_pulses", 64'(done_cnt - d0), 64'd1);
    chk("restart_results", 64'(n_results - r0), 64'(N_OUT));

    // Reset in the cycle after the second FETCH cycle
    load_push(tbl[0]);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    @(negedge clk);
    chk("rst_pre_mac_en", {63'd0, mac_en}, 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sb.delete();
    for (int c = 4; c <= 10; c++) begin
      @(negedge clk);
      chk($sformatf("rst_quiet_cyc%0d", c), {61'd0, busy, mac_en, out_valid}, 64'd0);
      tick();
    end
    run_layer(tbl[0], "after_rst");

    // start in the done cycle
    load_push(tbl[1]);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(ok);
    chk("donecyc_first_timeout", {63'd0, ok}, 64'd1);
    load_push(tbl[3]);
    start = 1'b1;
    tick();
    start = 1'b0;
    @(negedge clk);
    chk("donecyc_busy", {63'd0, busy}, 64'd1);
    wait_done(ok);
    chk("donecyc_second_timeout", {63'd0, ok}, 64'd1);
    tick();
    chk("donecyc_sb_empty", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, fails);
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
